// File: rtl/cvcdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : cvcdu_sequencer
// Brief   : Per-sync CVCDU frame controller. Feeds payload bytes one at a time
//           to the descrambler and tags each result with its RS lane and index.
// Revision: 1.0 - initial release
// ============================================================================
module cvcdu_sequencer #(
  parameter int FRAME_BYTES = 1020,
  parameter int INTERLEAVE  = 4,
  parameter int TIMEOUT     = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          sync_found_in,
  input  logic                          byte_valid_in,
  input  logic [7:0]                    byte_in,
  output logic                          byte_ready_out,
  output logic                          desc_new_out,
  output logic                          desc_valid_out,
  output logic [7:0]                    desc_byte_out,
  input  logic                          desc_valid_in,
  input  logic [7:0]                    desc_byte_in,
  output logic                          rs_valid_out,
  output logic [7:0]                    rs_byte_out,
  output logic [$clog2(INTERLEAVE)-1:0] rs_lane_out,
  output logic [7:0]                    rs_index_out,
  output logic                          frame_done_out,
  output logic                          frame_err_out,
  output logic                          busy_out
);

  localparam int c_cnt_w  = $clog2(FRAME_BYTES);
  localparam int c_tmr_w  = $clog2(TIMEOUT + 1);
  localparam int c_lane_w = $clog2(INTERLEAVE);

  localparam logic [c_cnt_w-1:0] c_last_byte = c_cnt_w'(FRAME_BYTES - 1);
  localparam logic [c_cnt_w-1:0] c_ilv       = c_cnt_w'(INTERLEAVE);
  localparam logic [c_tmr_w-1:0] c_tmo_last  = c_tmr_w'(TIMEOUT - 1);

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_start     = 3'd1;
  localparam logic [2:0] c_st_wait_byte = 3'd2;
  localparam logic [2:0] c_st_wait_desc = 3'd3;
  localparam logic [2:0] c_st_emit      = 3'd4;

  logic [2:0]          r_state;
  logic [c_cnt_w-1:0]  r_byte_count;
  logic [c_tmr_w-1:0]  r_timer;

  logic                r_byte_ready;
  logic                r_desc_new;
  logic                r_desc_valid;
  logic [7:0]          r_desc_byte;
  logic                r_rs_valid;
  logic [7:0]          r_rs_byte;
  logic [c_lane_w-1:0] r_rs_lane;
  logic [7:0]          r_rs_index;
  logic                r_frame_done;
  logic                r_frame_err;
  logic                r_busy;

  logic [2:0]          w_next;
  logic                w_accept;
  logic                w_capture;
  logic                w_abort;
  logic                w_timeout;
  logic                w_last;
  logic [c_lane_w-1:0] w_lane;
  logic [7:0]          w_index;

  assign w_last  = (r_byte_count == c_last_byte);
  assign w_lane  = c_lane_w'(r_byte_count % c_ilv);
  assign w_index = 8'(r_byte_count / c_ilv);

  // Resync outranks byte accept and descrambler results in every active state.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (sync_found_in) w_next = c_st_start;
      end
      c_st_start: begin
        if (sync_found_in) begin
          w_abort = 1'b1;
          w_next  = c_st_start;
        end else begin
          w_next = c_st_wait_byte;
        end
      end
      c_st_wait_byte: begin
        if (sync_found_in) begin
          w_abort = 1'b1;
          w_next  = c_st_start;
        end else if (byte_valid_in && r_byte_ready) begin
          w_accept = 1'b1;
          w_next   = c_st_wait_desc;
        end
      end
      c_st_wait_desc: begin
        if (sync_found_in) begin
          w_abort = 1'b1;
          w_next  = c_st_start;
        end else if (desc_valid_in) begin
          w_capture = 1'b1;
          w_next    = c_st_emit;
        end else if (r_timer == c_tmo_last) begin
          w_timeout = 1'b1;
          w_next    = c_st_idle;
        end
      end
      c_st_emit: begin
        // A sync landing on the final byte starts the next frame cleanly.
        if (w_last) begin
          w_next = sync_found_in ? c_st_start : c_st_idle;
        end else if (sync_found_in) begin
          w_abort = 1'b1;
          w_next  = c_st_start;
        end else begin
          w_next = c_st_wait_byte;
        end
      end
      default: w_next = c_st_idle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= c_st_idle;
      r_byte_count <= '0;
      r_timer      <= '0;
      r_byte_ready <= 1'b0;
      r_desc_new   <= 1'b0;
      r_desc_valid <= 1'b0;
      r_desc_byte  <= '0;
      r_rs_valid   <= 1'b0;
      r_rs_byte    <= '0;
      r_rs_lane    <= '0;
      r_rs_index   <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_byte_ready <= (w_next == c_st_wait_byte);
      r_desc_new   <= (w_next == c_st_start);
      r_desc_valid <= w_accept;
      r_rs_valid   <= w_capture;
      r_frame_done <= w_capture && w_last;
      r_frame_err  <= w_abort || w_timeout;
      r_busy       <= (w_next != c_st_idle);

      // desc_byte_out stays put until the next accept; the descrambler samples late.
      if (w_accept) begin
        r_desc_byte <= byte_in;
        r_timer     <= '0;
      end else if (r_state == c_st_wait_desc) begin
        r_timer <= r_timer + 1'b1;
      end

      if (r_state == c_st_start) begin
        r_byte_count <= '0;
      end else if ((r_state == c_st_emit) && (w_next == c_st_wait_byte)) begin
        r_byte_count <= r_byte_count + 1'b1;
      end

      if (w_capture) begin
        r_rs_byte  <= desc_byte_in;
        r_rs_lane  <= w_lane;
        r_rs_index <= w_index;
      end
    end
  end

  assign byte_ready_out = r_byte_ready;
  assign desc_new_out   = r_desc_new;
  assign desc_valid_out = r_desc_valid;
  assign desc_byte_out  = r_desc_byte;
  assign rs_valid_out   = r_rs_valid;
  assign rs_byte_out    = r_rs_byte;
  assign rs_lane_out    = r_rs_lane;
  assign rs_index_out   = r_rs_index;
  assign frame_done_out = r_frame_done;
  assign frame_err_out  = r_frame_err;
  assign busy_out       = r_busy;

endmodule
`default_nettype wire

// File: doc/cvcdu_sequencer.md
Name: cvcdu_sequencer

Overview:
- Frame-level controller between the ASM sync detector and the descrambler. It sequences one CVCDU per detected sync.
- On sync it pulses the descrambler restart, then feeds payload bytes one at a time under a handshake and waits for each descrambled result.
- It tags each result with its Reed-Solomon interleave lane and codeword position before forwarding it to the RS decoder.
- It detects frame completion, premature resync and descrambler stalls.

Parameters:
- FRAME_BYTES, 1020: CVCDU payload bytes per frame (ASM excluded).
- INTERLEAVE, 4: RS interleave depth; lane = byte_count mod INTERLEAVE.
- TIMEOUT, 32: maximum cycles to wait for the descrambler result before declaring an error.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- sync_found_in  input  1  single-cycle pulse; the next accepted byte is CVCDU byte 0
- byte_valid_in  input  1  upstream byte valid
- byte_in  input  8  upstream scrambled byte
- byte_ready_out  output  1  byte accepted when byte_valid_in && byte_ready_out
- desc_new_out  output  1  to descrambler cvcdu_new
- desc_valid_out  output  1  single-cycle byte strobe to descrambler
- desc_byte_out  output  8  byte to descrambler; held stable until result returns
- desc_valid_in  input  1  descrambler result strobe
- desc_byte_in  input  8  descrambled byte
- rs_valid_out  output  1  single-cycle output strobe
- rs_byte_out  output  8  descrambled byte
- rs_lane_out  output  $clog2(INTERLEAVE)  codeword lane
- rs_index_out  output  8  position within codeword (byte_count / INTERLEAVE)
- frame_done_out  output  1  pulse on the cycle the last byte is emitted
- frame_err_out  output  1  pulse on abort (resync or timeout)
- busy_out  output  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; byte_count = 0; timer = 0.
  - All outputs 0, including desc_byte_out and rs_byte_out.
- All outputs are registered.
- byte_count width is $clog2(FRAME_BYTES).
- FSM states:
  - IDLE: byte_ready_out = 0; upstream bytes are ignored. On sync_found_in go to START.
  - START: desc_new_out = 1 for exactly one cycle; byte_count cleared; go to WAIT_BYTE.
  - WAIT_BYTE: byte_ready_out = 1. On accept:
    - latch byte_in into desc_byte_out;
    - pulse desc_valid_out for one cycle;
    - clear timer; byte_ready_out drops next cycle; go to WAIT_DESC.
  - WAIT_DESC: byte_ready_out = 0; timer increments each cycle.
    - On desc_valid_in: register rs_byte_out = desc_byte_in, rs_lane_out, rs_index_out, and rs_valid_out = 1 the next cycle (1-cycle latency); go to EMIT.
    - If timer reaches TIMEOUT-1 without desc_valid_in: pulse frame_err_out; go to IDLE.
  - EMIT (one cycle):
    - If byte_count == FRAME_BYTES-1: frame_done_out pulses coincident with rs_valid_out; go to IDLE.
    - Otherwise byte_count += 1; go to WAIT_BYTE.
- One byte is in flight to the descrambler at a time. desc_byte_out is held from the strobe until desc_valid_in, because the descrambler samples it late.
- rs_lane_out = byte_count mod INTERLEAVE; rs_index_out = byte_count / INTERLEAVE. Last byte: lane 3, index 254.
- desc_valid_in outside WAIT_DESC is ignored.
- sync_found_in in any non-IDLE state:
  - pulse frame_err_out;
  - drop any in-flight result;
  - go to START (restart the frame).
  - Resync takes priority over byte accept and over desc_valid_in in the same cycle.
- sync_found_in in the same cycle as EMIT of the last byte: frame_done_out still pulses and no error is raised; the next state is START.
- Reset mid-frame: immediate return to the reset values above; no done or error pulse.

Test Plan:
1. Sync, then 1020 bytes of 0x00 with an LFSR-model descrambler (5-cycle latency) → rs_byte_out sequence 0xff, 0x48, 0x0e, 0xc0, 0x9a…; lanes 0,1,2,3,0; indices 0,0,0,0,1; frame_done_out on byte 1019 (lane 3, index 254); exactly one desc_new_out pulse, one cycle after the sync pulse.
2. Upstream byte_valid_in held high continuously → exactly one desc_valid_out per byte; desc_byte_out stable until desc_valid_in; byte_ready_out low throughout WAIT_DESC.
3. Second sync_found_in after 300 bytes → frame_err_out pulse; desc_new_out re-pulses; byte_count restarts at 0 (lane 0, index 0); no frame_done_out for the aborted frame.
4. Descrambler never answers byte 10 → frame_err_out exactly TIMEOUT cycles after the desc_valid_out strobe; state IDLE; later bytes not accepted until the next sync.
5. rst_n_in asserted mid-WAIT_DESC, result arrives during reset → all outputs 0 immediately; no rs_valid_out; after release, idle until sync.
6. Sync pulse coincident with EMIT of byte 1019 → frame_done_out = 1, frame_err_out = 0; the next frame starts with a desc_new_out pulse the following cycle.
